tc_io_tri_bank: RTL

TC_IO_TRI_BANK -- requirements
Module: tc_io_tri_bank

---
 rtl/tc_io_tri_bank.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tc_io_tri_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tc_io_tri_bank (with leaf cell tc_io_tri_pad)
// Brief    : Bank of CHNL tri-state pads with registered output/enable,
//            2-flop input synchroniser, optional glitch filter and
//            per-channel sticky edge/level interrupts.
// Options  : `define TC_IO_BANK_FILTER_EN builds the per-channel glitch
//            filter. Without it, in_o is the synchroniser output and
//            flt_thr_i is ignored.
// Revision : 1.0 - initial release
// ============================================================================

module tc_io_tri_pad (
  inout  wire  pad_io,
  input  logic c2p_i,
  input  logic c2p_en_i,
  output logic p2c_o
);
  assign pad_io = c2p_en_i ? c2p_i : 1'bz;
  assign p2c_o  = pad_io;
endmodule

module tc_io_tri_bank #(
  parameter int CHNL  = 8,
  parameter int FLT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  inout  wire  [CHNL-1:0]   pad_io,
  input  logic [CHNL-1:0]   out_i,
  input  logic [CHNL-1:0]   oen_i,
  output logic [CHNL-1:0]   in_o,
  input  logic [FLT_W-1:0]  flt_thr_i,
  input  logic [2*CHNL-1:0] irq_type_i,
  input  logic [CHNL-1:0]   irq_en_i,
  input  logic [CHNL-1:0]   irq_clr_i,
  output logic [CHNL-1:0]   irq_stat_o,
  output logic              irq_o
);

  localparam logic [1:0] IRQ_RISE  = 2'b00;
  localparam logic [1:0] IRQ_FALL  = 2'b01;
  localparam logic [1:0] IRQ_BOTH  = 2'b10;

  logic [CHNL-1:0] out_q, oen_q;
  logic [CHNL-1:0] p2c;
  logic [CHNL-1:0] sync1_q, sync2_q;
  logic [CHNL-1:0] in_q;
  logic [CHNL-1:0] evt;
  logic [CHNL-1:0] irq_stat_d, irq_stat_q;

  // One pad cell per channel, driven only from registered core data.
  for (genvar g = 0; g < CHNL; g++) begin : g_pad
    tc_io_tri_pad u_pad (
      .pad_io   (pad_io[g]),
      .c2p_i    (out_q[g]),
      .c2p_en_i (oen_q[g]),
      .p2c_o    (p2c[g])
    );
  end

  // Output register stage and two-flop synchroniser for the pad inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q   <= '0;
      oen_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      out_q   <= out_i;
      oen_q   <= oen_i;
      sync1_q <= p2c;
      sync2_q <= sync1_q;
    end
  end

`ifdef TC_IO_BANK_FILTER_EN
  logic [CHNL-1:0]            flt_d, flt_q;
  logic [CHNL-1:0][FLT_W-1:0] cnt_d, cnt_q;

  // Accept a new level once it has differed for flt_thr_i+1 compares. The
  // >= compare means a lowered threshold takes effect at once, and the
  // counter can never pass the largest threshold, so it never wraps.
  always_comb begin
    flt_d = flt_q;
    cnt_d = '0;
    for (int c = 0; c < CHNL; c++) begin
      if (sync2_q[c] != flt_q[c]) begin
        if (cnt_q[c] >= flt_thr_i) begin
          flt_d[c] = sync2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flt_q <= '0;
      cnt_q <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_o = flt_q;
`else
  logic unused_flt_thr;
  assign unused_flt_thr = ^flt_thr_i;
  assign in_o           = sync2_q;
`endif

  // Select the interrupt event per channel and merge it into sticky status;
  // a set in the same cycle as a clear wins.
  always_comb begin
    evt = '0;
    for (int c = 0; c < CHNL; c++) begin
      case (irq_type_i[2*c +: 2])
        IRQ_RISE: evt[c] = in_o[c] & ~in_q[c];
        IRQ_FALL: evt[c] = ~in_o[c] & in_q[c];
        IRQ_BOTH: evt[c] = in_o[c] ^ in_q[c];
        default:  evt[c] = in_o[c];
      endcase
    end
    irq_stat_d = (irq_stat_q & ~irq_clr_i) | (irq_en_i & evt);
  end

  // Delayed input copy for edge detection and the status register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_q       <= '0;
      irq_stat_q <= '0;
    end else begin
      in_q       <= in_o;
      irq_stat_q <= irq_stat_d;
    end
  end

  assign irq_stat_o = irq_stat_q;
  assign irq_o      = |irq_stat_q;

endmodule

`default_nettype wire
